// File: rtl/map_write_arbiter_pkg.sv
// Shared game types and constants for the terrain map, plus map write arbiter
// state and request payload types.
package map_write_arbiter_pkg;

    localparam int GAME_MAP_WIDTH  = 4;
    localparam int GAME_MAP_HEIGHT = 3;

    // One spare code above the last index so out-of-range requests are representable
    localparam int MAP_IDX_SIZE_X = $clog2(GAME_MAP_WIDTH + 1);
    localparam int MAP_IDX_SIZE_Y = $clog2(GAME_MAP_HEIGHT + 1);

    typedef logic [MAP_IDX_SIZE_X-1:0] map_x_t;
    typedef logic [MAP_IDX_SIZE_Y-1:0] map_y_t;
    typedef logic [1:0]                terrain_t;

    localparam map_x_t MAP_W_IDX  = map_x_t'(GAME_MAP_WIDTH);
    localparam map_y_t MAP_H_IDX  = map_y_t'(GAME_MAP_HEIGHT);
    localparam map_x_t MAP_X_LAST = map_x_t'(GAME_MAP_WIDTH - 1);
    localparam map_y_t MAP_Y_LAST = map_y_t'(GAME_MAP_HEIGHT - 1);

    typedef enum logic [1:0] {
        PRE_GAME,
        IN_GAME,
        GAME_OVER
    } game_state_t;

    typedef enum logic {
        MW_CLEAR,
        MW_SERVE
    } map_wr_state_t;

    typedef struct packed {
        map_x_t   x;
        map_y_t   y;
        terrain_t data;
    } map_wr_req_t;

endpackage

// File: rtl/map_write_arbiter_sweep_counter.sv
// Row-major (x inner) cell counter for the full-map clear sweep.
module map_sweep_counter
    import map_write_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   restart,
    input  logic   advance,
    output map_x_t cx,
    output map_y_t cy,
    output logic   last_cell
);

    assign last_cell = (cx == MAP_X_LAST) && (cy == MAP_Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (restart) begin
            cx <= '0;
            cy <= '0;
        end else if (advance) begin
            if (last_cell) begin
                cx <= '0;
                cy <= '0;
            end else if (cx == MAP_X_LAST) begin
                cx <= '0;
                cy <= cy + map_y_t'(1);
            end else begin
                cx <= cx + map_x_t'(1);
            end
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Terrain-map write port owner: clear sweep, then round-robin between loader
// and hazard spawner. Optional per-requester counters under MAP_WRITE_STATS_EN.
module map_write_arbiter
    import map_write_arbiter_pkg::*;
#(
    parameter terrain_t CLEAR_TERRAIN  = '0,
    parameter logic     CLEAR_ON_RESET = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear_req,
    input  logic     req0_valid,
    output logic     req0_ready,
    input  map_x_t   req0_x,
    input  map_y_t   req0_y,
    input  terrain_t req0_data,
    input  logic     req1_valid,
    output logic     req1_ready,
    input  map_x_t   req1_x,
    input  map_y_t   req1_y,
    input  terrain_t req1_data,
    output logic     map_ready,
    output logic     write_enable,
    output map_x_t   write_x,
    output map_y_t   write_y,
    output terrain_t write_data,
    output logic     drop_err
`ifdef MAP_WRITE_STATS_EN
    ,
    output logic [15:0] stat_wr0,
    output logic [15:0] stat_wr1
`endif
);

    map_wr_state_t state;
    logic          last_grant;
    logic          grant;
    logic          serving;
    logic          in_range;
    map_wr_req_t   sel_req;
    map_x_t        cx;
    map_y_t        cy;
    logic          last_cell;

    map_sweep_counter u_sweep (
        .clk       (clk),
        .reset     (reset),
        .restart   (clear_req),
        .advance   (state == MW_CLEAR),
        .cx        (cx),
        .cy        (cy),
        .last_cell (last_cell)
    );

    // Contention goes to whoever did not win last; a lone requester always wins
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
        serving    = (state == MW_SERVE) && !clear_req && (req0_valid || req1_valid);
        req0_ready = serving && !grant;
        req1_ready = serving && grant;
        sel_req    = grant ? map_wr_req_t'{x: req1_x, y: req1_y, data: req1_data}
                           : map_wr_req_t'{x: req0_x, y: req0_y, data: req0_data};
        in_range   = (sel_req.x < MAP_W_IDX) && (sel_req.y < MAP_H_IDX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= CLEAR_ON_RESET ? MW_CLEAR : MW_SERVE;
            last_grant   <= 1'b1;
            write_enable <= 1'b0;
            write_x      <= '0;
            write_y      <= '0;
            write_data   <= CLEAR_TERRAIN;
            map_ready    <= ~CLEAR_ON_RESET;
            drop_err     <= 1'b0;
`ifdef MAP_WRITE_STATS_EN
            stat_wr0     <= '0;
            stat_wr1     <= '0;
`endif
        end else if (clear_req) begin
            state        <= MW_CLEAR;
            map_ready    <= 1'b0;
            write_enable <= 1'b0;
            drop_err     <= 1'b0;
`ifdef MAP_WRITE_STATS_EN
            stat_wr0     <= '0;
            stat_wr1     <= '0;
`endif
        end else begin
            case (state)
                MW_CLEAR: begin
                    write_enable <= 1'b1;
                    write_x      <= cx;
                    write_y      <= cy;
                    write_data   <= CLEAR_TERRAIN;
                    if (last_cell) begin
                        state     <= MW_SERVE;
                        map_ready <= 1'b1;
                    end
                end
                MW_SERVE: begin
                    if (serving) begin
                        last_grant <= grant;
                        if (in_range) begin
                            write_enable <= 1'b1;
                            write_x      <= sel_req.x;
                            write_y      <= sel_req.y;
                            write_data   <= sel_req.data;
`ifdef MAP_WRITE_STATS_EN
                            if (!grant && stat_wr0 != '1)
                                stat_wr0 <= stat_wr0 + 16'd1;
                            if (grant && stat_wr1 != '1)
                                stat_wr1 <= stat_wr1 + 16'd1;
`endif
                        end else begin
                            write_enable <= 1'b0;
                            drop_err     <= 1'b1;
                        end
                    end else begin
                        write_enable <= 1'b0;
                    end
                end
                default: state <= MW_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed-vector bench for map_write_arbiter on the 4x3 map.
module tb_map_write_arbiter;
    import map_write_arbiter_pkg::*;

    localparam terrain_t CT = 2'b10;

    logic     clk, reset, clear_req;
    logic     req0_valid, req0_ready, req1_valid, req1_ready;
    map_x_t   req0_x, req1_x, write_x;
    map_y_t   req0_y, req1_y, write_y;
    terrain_t req0_data, req1_data, write_data;
    logic     map_ready, write_enable, drop_err;
`ifdef MAP_WRITE_STATS_EN
    logic [15:0] stat_wr0, stat_wr1;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    map_write_arbiter #(.CLEAR_TERRAIN(CT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear_req    (clear_req),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_x       (req0_x),
        .req0_y       (req0_y),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_x       (req1_x),
        .req1_y       (req1_y),
        .req1_data    (req1_data),
        .map_ready    (map_ready),
        .write_enable (write_enable),
        .write_x      (write_x),
        .write_y      (write_y),
        .write_data   (write_data),
        .drop_err     (drop_err)
`ifdef MAP_WRITE_STATS_EN
        ,
        .stat_wr0     (stat_wr0),
        .stat_wr1     (stat_wr1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic     r0v;
        map_x_t   r0x;
        map_y_t   r0y;
        terrain_t r0d;
        logic     r1v;
        map_x_t   r1x;
        map_y_t   r1y;
        terrain_t r1d;
        logic     clr;
        logic     e_r0rdy;
        logic     e_r1rdy;
        logic     e_we;
        map_x_t   e_x;
        map_y_t   e_y;
        terrain_t e_d;
        logic     e_mr;
        logic     e_drop;
        logic     chk_pay;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(int r0v, int r0x, int r0y, int r0d,
                                int r1v, int r1x, int r1y, int r1d, int clr,
                                int er0, int er1, int we, int ex, int ey, int ed,
                                int mr, int drop, int pay);
        vec_t v;
        v.r0v = (r0v != 0);     v.r0x = map_x_t'(r0x);
        v.r0y = map_y_t'(r0y);  v.r0d = terrain_t'(r0d);
        v.r1v = (r1v != 0);     v.r1x = map_x_t'(r1x);
        v.r1y = map_y_t'(r1y);  v.r1d = terrain_t'(r1d);
        v.clr = (clr != 0);
        v.e_r0rdy = (er0 != 0); v.e_r1rdy = (er1 != 0);
        v.e_we = (we != 0);     v.e_x = map_x_t'(ex);
        v.e_y = map_y_t'(ey);   v.e_d = terrain_t'(ed);
        v.e_mr = (mr != 0);     v.e_drop = (drop != 0);
        v.chk_pay = (pay != 0);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int we, input int x, input int y,
                           input int d, input int mr, input int drop, input bit pay);
        chk({tag, " write_enable"}, int'(write_enable), we);
        if (pay) begin
            chk({tag, " write_x"}, int'(write_x), x);
            chk({tag, " write_y"}, int'(write_y), y);
            chk({tag, " write_data"}, int'(write_data), d);
        end
        chk({tag, " map_ready"}, int'(map_ready), mr);
        chk({tag, " drop_err"}, int'(drop_err), drop);
    endtask

    // Full 12-cell sweep; caller is positioned just after an edge with state CLEAR
    task automatic do_sweep(input string tag);
        for (int e = 0; e < GAME_MAP_WIDTH * GAME_MAP_HEIGHT; e++) begin
            chk({tag, " sweep req0_ready"}, int'(req0_ready), 0);
            chk({tag, " sweep req1_ready"}, int'(req1_ready), 0);
            @(posedge clk); #1;
            chk_out($sformatf("%s sweep edge %0d", tag, e + 1), 1, e % GAME_MAP_WIDTH,
                    e / GAME_MAP_WIDTH, int'(CT),
                    (e == GAME_MAP_WIDTH * GAME_MAP_HEIGHT - 1) ? 1 : 0, 0, 1'b1);
        end
    endtask

    initial begin
        //           r0v x y d  r1v x y d  clr  rdy0 rdy1  we x y d  mr drop pay
        vecs[0]  = mk(1, 1,1,1, 1, 2,2,3, 0,   1,0,  1, 1,1,1, 1,0,1);
        vecs[1]  = mk(1, 3,0,2, 1, 2,2,3, 0,   0,1,  1, 2,2,3, 1,0,1);
        vecs[2]  = mk(1, 3,0,2, 1, 0,1,1, 0,   1,0,  1, 3,0,2, 1,0,1);
        vecs[3]  = mk(1, 0,2,3, 1, 0,1,1, 0,   0,1,  1, 0,1,1, 1,0,1);
        vecs[4]  = mk(0, 0,2,3, 1, 1,2,2, 0,   0,1,  1, 1,2,2, 1,0,1);
        vecs[5]  = mk(0, 0,0,0, 1, 2,0,3, 0,   0,1,  1, 2,0,3, 1,0,1);
        vecs[6]  = mk(0, 0,0,0, 1, 3,1,1, 0,   0,1,  1, 3,1,1, 1,0,1);
        vecs[7]  = mk(0, 0,0,0, 0, 0,0,0, 0,   0,0,  0, 3,1,1, 1,0,1);
        vecs[8]  = mk(1, 4,1,2, 0, 0,0,0, 0,   1,0,  0, 3,1,1, 1,1,1);
        vecs[9]  = mk(1, 2,1,3, 0, 0,0,0, 0,   1,0,  1, 2,1,3, 1,1,1);
        vecs[10] = mk(0, 0,0,0, 1, 1,3,1, 0,   0,1,  0, 2,1,3, 1,1,1);
        vecs[11] = mk(1, 3,2,0, 1, 0,0,2, 0,   1,0,  1, 3,2,0, 1,1,1);
        vecs[12] = mk(1, 0,0,1, 1, 1,1,2, 1,   0,0,  0, 0,0,0, 0,0,0);

        reset = 1'b1; clear_req = 1'b0;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_data = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, int'(CT), 0, 0, 1'b1);
        chk("reset req0_ready", int'(req0_ready), 0);
        chk("reset req1_ready", int'(req1_ready), 0);
        reset = 1'b0;
        do_sweep("power-up");

        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].r0v; req0_x = vecs[i].r0x;
            req0_y = vecs[i].r0y;     req0_data = vecs[i].r0d;
            req1_valid = vecs[i].r1v; req1_x = vecs[i].r1x;
            req1_y = vecs[i].r1y;     req1_data = vecs[i].r1d;
            clear_req = vecs[i].clr;
            #1;
            chk($sformatf("vec%0d req0_ready", i), int'(req0_ready), int'(vecs[i].e_r0rdy));
            chk($sformatf("vec%0d req1_ready", i), int'(req1_ready), int'(vecs[i].e_r1rdy));
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", i), int'(vecs[i].e_we), int'(vecs[i].e_x),
                    int'(vecs[i].e_y), int'(vecs[i].e_d), int'(vecs[i].e_mr),
                    int'(vecs[i].e_drop), vecs[i].chk_pay);
        end

        // Both requesters keep pushing through the rerun sweep; neither is accepted
        clear_req = 1'b0;
        do_sweep("after clear");

        // Last winner before the clear was req0, so req1 is next in line
        #1;
        chk("post-clear req0_ready", int'(req0_ready), 0);
        chk("post-clear req1_ready", int'(req1_ready), 1);
        @(posedge clk); #1;
        chk_out("post-clear write", 1, 1, 1, 2, 1, 0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset in the middle of a sweep, right after cell (2,1) goes out
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        chk_out("mid clear", 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk_out("mid cell (2,1)", 1, 2, 1, int'(CT), 0, 0, 1'b1);
        reset = 1'b1;
        #1;
        chk_out("mid reset", 0, 0, 0, int'(CT), 0, 0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        do_sweep("after mid reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
